// File: rtl/vector_issue_pkg.sv
// Shared types for the vector issue stage: FSM state encoding and the remapped
// instruction word produced by the register-remapping stage.
package vector_issue_pkg;

  localparam int VREG_W   = 5;
  localparam int TICKET_W = 4;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    RCFG  = 2'd2
  } vissue_state_e;

  // lock: 01 = store (dst_iszero set upstream), 11 = load, others = arithmetic.
  typedef struct packed {
    logic [7:0]          opcode;
    logic [1:0]          lock;
    logic                reconfigure;
    logic                use_mask;
    logic [VREG_W-1:0]   mask_src;
    logic [VREG_W-1:0]   src1;
    logic                src1_iszero;
    logic [VREG_W-1:0]   src2;
    logic                src2_iszero;
    logic [VREG_W-1:0]   dst;
    logic                dst_iszero;
    logic [TICKET_W-1:0] ticket;
  } remapped_v_instr;

endpackage

// File: rtl/vector_issue_scoreboard.sv
// Ticket-tagged pending-write scoreboard for the vector register file. A
// writeback clears a register only if it carries the ticket of the newest writer.
module vis_scoreboard
  import vector_issue_pkg::*;
#(
  parameter int VECTOR_REGISTERS   = 32,
  parameter int VECTOR_TICKET_BITS = TICKET_W,
  localparam int AW = $clog2(VECTOR_REGISTERS)
) (
  input  logic                          clk_i,
  input  logic                          rstn_i,
  input  logic                          set_valid_i,
  input  logic [AW-1:0]                 set_dst_i,
  input  logic [VECTOR_TICKET_BITS-1:0] set_ticket_i,
  input  logic                          wb_valid_i,
  input  logic [AW-1:0]                 wb_dst_i,
  input  logic [VECTOR_TICKET_BITS-1:0] wb_ticket_i,
  input  logic                          clr_all_i,
  input  logic [AW-1:0]                 rd_src1_i,
  input  logic [AW-1:0]                 rd_src2_i,
  input  logic [AW-1:0]                 rd_dst_i,
  input  logic [AW-1:0]                 rd_mask_i,
  output logic                          pend_src1_o,
  output logic                          pend_src2_o,
  output logic                          pend_dst_o,
  output logic                          pend_mask_o,
  output logic                          all_clear_o
);

  logic [VECTOR_REGISTERS-1:0]   r_pending;
  logic [VECTOR_TICKET_BITS-1:0] r_ticket [VECTOR_REGISTERS];

  // NOTE: these are flop arrays holding control state, so they take the async
  // reset; a stale pending bit after reset would deadlock the issue stage.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_pending <= '0;
      for (int i = 0; i < VECTOR_REGISTERS; i++) r_ticket[i] <= '0;
    end else if (clr_all_i) begin
      r_pending <= '0;
      for (int i = 0; i < VECTOR_REGISTERS; i++) r_ticket[i] <= '0;
    end else begin
      if (wb_valid_i && (r_ticket[wb_dst_i] == wb_ticket_i)) begin
        r_pending[wb_dst_i] <= 1'b0;
      end
      // NOTE: the later non-blocking assignment wins, so a same-edge set on the
      // retiring register leaves it pending under the new ticket.
      if (set_valid_i) begin
        r_pending[set_dst_i] <= 1'b1;
        r_ticket[set_dst_i]  <= set_ticket_i;
      end
    end
  end

  assign pend_src1_o = r_pending[rd_src1_i];
  assign pend_src2_o = r_pending[rd_src2_i];
  assign pend_dst_o  = r_pending[rd_dst_i];
  assign pend_mask_o = r_pending[rd_mask_i];
  assign all_clear_o = ~|r_pending;

endmodule

// File: rtl/vector_issue.sv
// In-order vector issue stage: instruction FIFO, hazard check against the
// scoreboard, and a drain/reconfigure FSM that serialises reconfigure instructions.
module vector_issue
  import vector_issue_pkg::*;
#(
  parameter int DEPTH              = 4,
  parameter int VECTOR_REGISTERS   = 32,
  parameter int VECTOR_TICKET_BITS = TICKET_W,
  localparam int AW = $clog2(VECTOR_REGISTERS)
) (
  input  logic                          clk_i,
  input  logic                          rstn_i,
  input  logic                          valid_i,
  input  remapped_v_instr               instr_i,
  output logic                          ready_o,
  output logic                          issue_valid_o,
  output remapped_v_instr               issue_instr_o,
  input  logic                          issue_ready_i,
  input  logic                          wb_valid_i,
  input  logic [AW-1:0]                 wb_dst_i,
  input  logic [VECTOR_TICKET_BITS-1:0] wb_ticket_i,
  output logic                          is_idle_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  remapped_v_instr r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  vissue_state_e    r_state;
  vissue_state_e    w_state_nxt;

  logic            w_empty;
  logic            w_push;
  logic            w_pop;
  logic            w_hazard;
  logic            w_issue_valid;
  logic            w_clr_all;
  logic            w_set;
  logic            w_all_clear;
  logic            w_pend_src1;
  logic            w_pend_src2;
  logic            w_pend_dst;
  logic            w_pend_mask;
  remapped_v_instr w_head;

  assign w_empty = (r_count == '0);
  assign ready_o = (r_count != CNT_W'(DEPTH));
  assign w_push  = valid_i & ready_o;
  assign w_pop   = w_issue_valid & issue_ready_i;
  assign w_head  = r_mem[r_rd_ptr];

  // NOTE: the instruction storage is data only and is not reset; the head is
  // masked to zero while the FIFO is empty, so nothing stale reaches the lanes.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= instr_i;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign w_hazard = (w_pend_src1 & ~w_head.src1_iszero)
                  | (w_pend_src2 & ~w_head.src2_iszero)
                  | (w_pend_mask &  w_head.use_mask)
                  | (w_pend_dst  & ~w_head.dst_iszero);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) r_state <= RUN;
    else         r_state <= w_state_nxt;
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    w_state_nxt   = r_state;
    w_issue_valid = 1'b0;
    w_clr_all     = 1'b0;
    case (r_state)
      RUN: begin
        if (!w_empty) begin
          if (w_head.reconfigure) w_state_nxt   = DRAIN;
          else                    w_issue_valid = ~w_hazard;
        end
      end
      DRAIN: begin
        if (w_all_clear) w_state_nxt = RCFG;
      end
      RCFG: begin
        w_issue_valid = ~w_empty;
        if (w_issue_valid && issue_ready_i) begin
          w_state_nxt = RUN;
          w_clr_all   = 1'b1;
        end
      end
      default: w_state_nxt = RUN;
    endcase
  end

  // Reconfigure and zero-destination instructions (stores) claim no register.
  assign w_set = w_pop & ~w_head.dst_iszero & ~w_head.reconfigure;

  vis_scoreboard #(
    .VECTOR_REGISTERS  (VECTOR_REGISTERS),
    .VECTOR_TICKET_BITS(VECTOR_TICKET_BITS)
  ) u_scoreboard (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .set_valid_i (w_set),
    .set_dst_i   (w_head.dst),
    .set_ticket_i(w_head.ticket),
    .wb_valid_i  (wb_valid_i),
    .wb_dst_i    (wb_dst_i),
    .wb_ticket_i (wb_ticket_i),
    .clr_all_i   (w_clr_all),
    .rd_src1_i   (w_head.src1),
    .rd_src2_i   (w_head.src2),
    .rd_dst_i    (w_head.dst),
    .rd_mask_i   (w_head.mask_src),
    .pend_src1_o (w_pend_src1),
    .pend_src2_o (w_pend_src2),
    .pend_dst_o  (w_pend_dst),
    .pend_mask_o (w_pend_mask),
    .all_clear_o (w_all_clear)
  );

  assign issue_valid_o = w_issue_valid;
  assign issue_instr_o = w_empty ? '0 : w_head;
  assign is_idle_o     = w_empty & w_all_clear;

endmodule

// File: tb/tb_vector_issue.sv
// Self-checking bench for vector_issue: a queue scoreboard checks issue order and
// content, directed checks cover hazard timing, full FIFO, reconfigure and reset.
module tb_vector_issue;
  import vector_issue_pkg::*;

  logic            clk_i = 1'b0;
  logic            rstn_i = 1'b0;
  logic            valid_i = 1'b0;
  remapped_v_instr instr_i = '0;
  logic            ready_o;
  logic            issue_valid_o;
  remapped_v_instr issue_instr_o;
  logic            issue_ready_i = 1'b0;
  logic            wb_valid_i = 1'b0;
  logic [4:0]      wb_dst_i = '0;
  logic [3:0]      wb_ticket_i = '0;
  logic            is_idle_o;

  int n_vec = 0;
  int n_err = 0;
  remapped_v_instr exp_q [$];

  vector_issue #(.DEPTH(4), .VECTOR_REGISTERS(32), .VECTOR_TICKET_BITS(4)) dut (
    .clk_i        (clk_i),
    .rstn_i       (rstn_i),
    .valid_i      (valid_i),
    .instr_i      (instr_i),
    .ready_o      (ready_o),
    .issue_valid_o(issue_valid_o),
    .issue_instr_o(issue_instr_o),
    .issue_ready_i(issue_ready_i),
    .wb_valid_i   (wb_valid_i),
    .wb_dst_i     (wb_dst_i),
    .wb_ticket_i  (wb_ticket_i),
    .is_idle_o    (is_idle_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic remapped_v_instr mk(input logic [4:0] dst, input logic [3:0] tkt);
    remapped_v_instr r;
    r             = '0;
    r.opcode      = {3'b101, dst} ^ {tkt, 4'h3};
    r.lock        = 2'b10;
    r.src1_iszero = 1'b1;
    r.src2_iszero = 1'b1;
    r.dst         = dst;
    r.ticket      = tkt;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input remapped_v_instr ins);
    valid_i = 1'b1;
    instr_i = ins;
  endtask

  task automatic idle();
    valid_i = 1'b0;
  endtask

  task automatic retire(input logic [4:0] dst, input logic [3:0] tkt);
    wb_valid_i  = 1'b1;
    wb_dst_i    = dst;
    wb_ticket_i = tkt;
    tick();
    wb_valid_i  = 1'b0;
  endtask

  // Handshakes are sampled mid-cycle, where inputs and outputs are both settled.
  always @(negedge clk_i) begin
    if (rstn_i) begin
      if (issue_valid_o && issue_ready_i) begin
        if (exp_q.size() == 0) begin
          check("issue_unexpected", 64'(issue_instr_o), 64'h0);
        end else begin
          check("issue_instr", 64'(issue_instr_o), 64'(exp_q.pop_front()));
        end
      end
      if (valid_i && ready_o) exp_q.push_back(instr_i);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    remapped_v_instr ins;

    // Reset values
    #2;
    check("rst_ready", 64'(ready_o), 64'h1);
    check("rst_issue_valid", 64'(issue_valid_o), 64'h0);
    check("rst_idle", 64'(is_idle_o), 64'h1);
    check("rst_issue_instr", 64'(issue_instr_o), 64'h0);
    tick();
    rstn_i = 1'b1;

    // Independent instructions back to back, then WAW on vreg 6
    issue_ready_i = 1'b1;
    drive(mk(5'd2, 4'd1)); tick();
    check("indep_valid0", 64'(issue_valid_o), 64'h1);
    check("indep_dst0", 64'(issue_instr_o.dst), 64'd2);
    drive(mk(5'd4, 4'd2)); tick();
    check("indep_valid1", 64'(issue_valid_o), 64'h1);
    check("indep_dst1", 64'(issue_instr_o.dst), 64'd4);
    check("indep_ready1", 64'(ready_o), 64'h1);
    drive(mk(5'd6, 4'd3)); tick();
    check("indep_valid2", 64'(issue_valid_o), 64'h1);
    check("indep_dst2", 64'(issue_instr_o.dst), 64'd6);
    check("indep_ready2", 64'(ready_o), 64'h1);
    drive(mk(5'd6, 4'd4)); tick(); idle();
    check("waw_stall", 64'(issue_valid_o), 64'h0);
    tick();
    check("waw_stall_hold", 64'(issue_valid_o), 64'h0);
    retire(5'd6, 4'd3);
    check("waw_release", 64'(issue_valid_o), 64'h1);
    tick();
    retire(5'd2, 4'd1); retire(5'd4, 4'd2); retire(5'd6, 4'd4);
    check("indep_idle", 64'(is_idle_o), 64'h1);

    // RAW on src1: issues the cycle after the retire, not the same cycle
    drive(mk(5'd4, 4'd3)); tick();
    ins = mk(5'd5, 4'd4); ins.src1 = 5'd4; ins.src1_iszero = 1'b0;
    drive(ins); tick(); idle();
    check("raw_stall", 64'(issue_valid_o), 64'h0);
    tick();
    check("raw_stall_hold", 64'(issue_valid_o), 64'h0);
    wb_valid_i = 1'b1; wb_dst_i = 5'd4; wb_ticket_i = 4'd3;
    #1;
    check("raw_no_bypass", 64'(issue_valid_o), 64'h0);
    tick(); wb_valid_i = 1'b0;
    check("raw_release", 64'(issue_valid_o), 64'h1);
    tick();
    retire(5'd5, 4'd4);

    // Stale retire on a masked reader: ticket 3 is ignored, ticket 5 clears
    drive(mk(5'd4, 4'd3)); tick(); idle(); tick();
    retire(5'd4, 4'd3);
    drive(mk(5'd4, 4'd5)); tick(); idle(); tick();
    ins = mk(5'd7, 4'd6); ins.use_mask = 1'b1; ins.mask_src = 5'd4;
    drive(ins); tick(); idle();
    check("mask_stall", 64'(issue_valid_o), 64'h0);
    retire(5'd4, 4'd3);
    check("stale_retire", 64'(issue_valid_o), 64'h0);
    retire(5'd4, 4'd5);
    check("fresh_retire", 64'(issue_valid_o), 64'h1);
    tick();
    retire(5'd7, 4'd6);

    // Same-edge set and matching stale clear on vreg 4: set wins
    drive(mk(5'd4, 4'd9)); tick(); idle();
    check("same_edge_head", 64'(issue_valid_o), 64'h1);
    wb_valid_i = 1'b1; wb_dst_i = 5'd4; wb_ticket_i = 4'd5;
    tick(); wb_valid_i = 1'b0;
    ins = mk(5'd10, 4'd10); ins.src2 = 5'd4; ins.src2_iszero = 1'b0;
    drive(ins); tick(); idle();
    check("same_edge_set_wins", 64'(issue_valid_o), 64'h0);
    retire(5'd4, 4'd9);
    check("same_edge_release", 64'(issue_valid_o), 64'h1);
    tick();
    retire(5'd10, 4'd10);
    check("same_edge_idle", 64'(is_idle_o), 64'h1);

    // Full FIFO with the lanes stalled
    issue_ready_i = 1'b0;
    drive(mk(5'd11, 4'd1)); tick();
    check("fill1_ready", 64'(ready_o), 64'h1);
    drive(mk(5'd12, 4'd2)); tick();
    drive(mk(5'd13, 4'd3)); tick();
    check("fill3_ready", 64'(ready_o), 64'h1);
    drive(mk(5'd14, 4'd4)); tick(); idle();
    check("full_ready", 64'(ready_o), 64'h0);
    check("full_head_valid", 64'(issue_valid_o), 64'h1);
    issue_ready_i = 1'b1; tick();
    check("pop_ready", 64'(ready_o), 64'h1);
    drive(mk(5'd15, 4'd5)); tick();
    check("push_pop_ready", 64'(ready_o), 64'h1);
    issue_ready_i = 1'b0;
    drive(mk(5'd16, 4'd6)); tick(); idle();
    check("refull_ready", 64'(ready_o), 64'h0);
    issue_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check("drained_valid", 64'(issue_valid_o), 64'h0);
    check("drained_busy", 64'(is_idle_o), 64'h0);
    for (int i = 0; i < 6; i++) retire(5'(11 + i), 4'(1 + i));
    check("full_idle", 64'(is_idle_o), 64'h1);

    // Reconfigure: drain vregs 0 and 8, then RCFG holds until accepted
    drive(mk(5'd0, 4'd1)); tick();
    drive(mk(5'd8, 4'd2)); tick(); idle(); tick();
    issue_ready_i = 1'b0;
    ins = mk(5'd0, 4'd0); ins.reconfigure = 1'b1; ins.dst_iszero = 1'b1; ins.lock = 2'b00;
    drive(ins); tick(); idle();
    check("rcfg_run_hold", 64'(issue_valid_o), 64'h0);
    tick();
    check("rcfg_drain", 64'(issue_valid_o), 64'h0);
    retire(5'd0, 4'd1);
    check("rcfg_drain_one", 64'(issue_valid_o), 64'h0);
    retire(5'd8, 4'd2);
    check("rcfg_drain_last", 64'(issue_valid_o), 64'h0);
    tick();
    check("rcfg_valid", 64'(issue_valid_o), 64'h1);
    check("rcfg_head", 64'(issue_instr_o.reconfigure), 64'h1);
    tick();
    check("rcfg_hold", 64'(issue_valid_o), 64'h1);
    issue_ready_i = 1'b1; tick();
    check("rcfg_done_valid", 64'(issue_valid_o), 64'h0);
    check("rcfg_idle", 64'(is_idle_o), 64'h1);

    // A store claims no register: a reader of its dst is not stalled
    ins = mk(5'd3, 4'd0); ins.lock = 2'b01; ins.dst_iszero = 1'b1;
    drive(ins); tick();
    ins = mk(5'd9, 4'd1); ins.src1 = 5'd3; ins.src1_iszero = 1'b0;
    drive(ins); tick(); idle();
    check("store_no_pending", 64'(issue_valid_o), 64'h1);
    tick();
    retire(5'd9, 4'd1);

    // Async reset with 3 queued and 2 pending
    drive(mk(5'd20, 4'd1)); tick();
    drive(mk(5'd21, 4'd2)); tick();
    drive(mk(5'd22, 4'd3)); tick();
    issue_ready_i = 1'b0;
    drive(mk(5'd23, 4'd4)); tick();
    drive(mk(5'd24, 4'd5)); tick(); idle();
    check("pre_rst_valid", 64'(issue_valid_o), 64'h1);
    #3 rstn_i = 1'b0;
    #1;
    check("arst_valid", 64'(issue_valid_o), 64'h0);
    check("arst_ready", 64'(ready_o), 64'h1);
    check("arst_idle", 64'(is_idle_o), 64'h1);
    check("arst_instr", 64'(issue_instr_o), 64'h0);
    exp_q.delete();
    tick();
    rstn_i = 1'b1;
    retire(5'd20, 4'd1);
    check("post_rst_retire_idle", 64'(is_idle_o), 64'h1);
    issue_ready_i = 1'b1;
    drive(mk(5'd25, 4'd1)); tick(); idle();
    check("post_rst_valid", 64'(issue_valid_o), 64'h1);
    check("post_rst_dst", 64'(issue_instr_o.dst), 64'd25);
    tick();
    check("post_rst_pending", 64'(is_idle_o), 64'h0);
    retire(5'd25, 4'd1);
    check("post_rst_idle", 64'(is_idle_o), 64'h1);

    tick();
    check("queue_drained", 64'(exp_q.size()), 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
